// File: rtl/generic_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : generic_bus_arb_pkg
// Brief   : Shared state encoding and index-width helper for the bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package generic_bus_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int arb_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational picker; first active request at or after start_ptr,
//           wrapping modulo N_REQ.
// Revision: 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import generic_bus_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IDX_W = arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] c_n_req = (IDX_W+1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W:0]   w_sum;

    // Rotate so bit k of w_rot is requestor (start_ptr + k) mod N_REQ
    assign w_rot = N_REQ'({req, req} >> start_ptr);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        w_sum = '0;
        // Descending scan: the lowest rotated position is written last and wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, start_ptr} + (IDX_W+1)'(k);
                valid = 1'b1;
            end
        end
        if (w_sum >= c_n_req) begin
            w_sum = w_sum - c_n_req;
        end
        idx = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/generic_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : generic_bus_arbiter
// Brief   : N-requestor generic-bus arbiter, grant held until the slave drops
//           busy. Define GENERIC_BUS_ARB_FIXED_PRIO_EN for fixed lowest-index
//           priority instead of round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module generic_bus_arbiter
    import generic_bus_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [N_REQ*ADDR_W-1:0]       req_addr,
    input  logic [N_REQ*DATA_W-1:0]       req_wdata,
    input  logic [N_REQ-1:0]              req_ren,
    input  logic [N_REQ-1:0]              req_wen,
    input  logic [N_REQ*(DATA_W/8)-1:0]   req_byte_en,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [N_REQ-1:0]              req_busy,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [DATA_W-1:0]             out_wdata,
    output logic                          out_ren,
    output logic                          out_wen,
    output logic [DATA_W/8-1:0]           out_byte_en,
    input  logic [DATA_W-1:0]             out_rdata,
    input  logic                          out_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = arb_idx_w(N_REQ);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [IDX_W-1:0]  w_start;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_valid;
    logic [N_REQ-1:0]  w_active;
    logic              w_release;

    logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
    logic [DATA_W-1:0] w_wdata_arr [N_REQ];
    logic [BE_W-1:0]   w_be_arr    [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        assign w_be_arr[i]    = req_byte_en[i*BE_W +: BE_W];
    end

    assign w_active  = req_ren | req_wen;
    assign req_rdata = out_rdata;

    // Leave GRANT on completion (active, not busy) or on abort (not active)
    assign w_release = (r_state == GRANT) && !(w_active[r_grant_idx] && out_busy);

    rr_priority_picker #(
        .N_REQ     (N_REQ)
    ) u_picker (
        .req       (w_active),
        .start_ptr (w_start),
        .idx       (w_pick_idx),
        .valid     (w_pick_valid)
    );

`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr <= '0;
        end else if (w_release) begin
            r_rr_ptr <= (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant_idx <= w_pick_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_addr    = '0;
        out_wdata   = '0;
        out_ren     = 1'b0;
        out_wen     = 1'b0;
        out_byte_en = '0;
        req_busy    = '1;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                out_addr              = w_addr_arr[r_grant_idx];
                out_wdata             = w_wdata_arr[r_grant_idx];
                out_ren               = req_ren[r_grant_idx];
                out_wen               = req_wen[r_grant_idx];
                out_byte_en           = w_be_arr[r_grant_idx];
                req_busy[r_grant_idx] = out_busy;
                if (w_release) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/generic_bus_arbiter.md
Name: generic_bus_arbiter

Overview:
- N-requestor arbiter that multiplexes several generic-bus masters (fetch, LSU, debug, DMA) onto one downstream generic-bus slave.
- Parametrised in requestor count and address/data width.
- Registers the grant, holds it for the whole transfer (until downstream busy drops), then arbitrates round-robin.
- Sits between the core's memory-side masters and the RAM/bus bridge.

Parameters:
- N_REQ, 2, number of requestors; legal range 2..16, need not be a power of two.
- ADDR_W, 32, address width (RAM_ADDR_SIZE in system use).
- DATA_W, 32, data width (word_t in system use); byte-enable width is DATA_W/8.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_addr  in  N_REQ*ADDR_W  packed requestor addresses; requestor i is in slice i.
- req_wdata  in  N_REQ*DATA_W  packed requestor write data.
- req_ren  in  N_REQ  per-requestor read request.
- req_wen  in  N_REQ  per-requestor write request.
- req_byte_en  in  N_REQ*(DATA_W/8)  packed byte enables.
- req_rdata  out  DATA_W  downstream read data, broadcast to all requestors.
- req_busy  out  N_REQ  per-requestor busy.
- out_addr  out  ADDR_W  downstream address.
- out_wdata  out  DATA_W  downstream write data.
- out_ren  out  1  downstream read request.
- out_wen  out  1  downstream write request.
- out_byte_en  out  DATA_W/8  downstream byte enables.
- out_rdata  in  DATA_W  downstream read data.
- out_busy  in  1  downstream busy.

Behaviour:
- Protocol: a master holds ren or wen, plus addr, wdata and byte_en, stable until it sees busy=0. A cycle with request high and busy=0 completes the transfer; rdata is valid in that cycle.
- Active request of requestor i: req_ren[i] | req_wen[i].
- State machine states: IDLE and GRANT.
- Reset: state=IDLE, grant_idx=0, rr_ptr=0.
- IDLE:
  - All out_* request/data outputs are 0.
  - req_busy is all ones.
  - If any request is active, the picker selects the first active index searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - grant_idx is registered with that index; next state is GRANT.
  - No request active: stay in IDLE.
- GRANT:
  - out_addr, out_wdata, out_ren, out_wen and out_byte_en pass the granted requestor's signals combinationally.
  - req_busy[grant_idx] = out_busy; every other req_busy bit is 1.
  - req_rdata = out_rdata in all states.
- Completion (GRANT with granted request active and out_busy=0):
  - rr_ptr <= (grant_idx==N_REQ-1) ? 0 : grant_idx+1.
  - Next state is IDLE.
- Abort (GRANT with granted requestor's ren and wen both 0):
  - out_ren and out_wen are 0 that cycle.
  - Next state is IDLE; rr_ptr advances exactly as on completion.
- Latency: one added arbitration cycle per transfer. Minimum is 2 cycles from request to completion with a zero-wait slave.
- Simultaneous requests: exactly one grant. Losing requestors see busy=1 and must keep their requests asserted.
- Fairness: with all N_REQ requesting continuously, each requestor is served once per N_REQ transfers.
- Simultaneous ren and wen from one requestor: both pass to the slave unchanged; the arbiter does not police this.
- Reset asserted mid-transfer: the arbiter returns to the reset state immediately, downstream requests drop, req_busy goes all ones.

Optional Feature:
- Macro: GENERIC_BUS_ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed and the picker always searches from index 0, so the lowest active index wins.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package generic_bus_arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT};
  - function arb_idx_w(n) returning $clog2(n).
- Word/address types continue to come from rv32i_types_pkg.
- One sub-module, rr_priority_picker:
  - combinational;
  - inputs: request vector and start pointer;
  - outputs: chosen index and a valid bit;
  - parametrised by N_REQ.

Test Plan:
1. Reset, N_REQ=2, zero-wait slave: req_ren[0]=1, addr 0x100, out_rdata 0xDEADBEEF.
   -> Cycle 1: out_ren=0, busy[0]=1.
   -> Cycle 2: out_ren=1, out_addr=0x100, req_busy=2'b10, req_rdata=0xDEADBEEF.
2. Both requestors request from reset, rr_ptr=0.
   -> Requestor 0 served first, then requestor 1, then requestor 0; grants alternate every 2 cycles.
3. N_REQ=3, all request continuously.
   -> Grant order 0,1,2,0; rr_ptr wraps from 2 to 0.
4. Slave holds out_busy=1 for 3 cycles during requestor 1's write, while requestor 0 also requests.
   -> grant_idx stays 1.
   -> out_wen=1, out_wdata held, req_busy[0]=1 throughout.
   -> Requestor 0 is granted only after requestor 1 completes.
5. Granted requestor drops ren before completion.
   -> out_ren=0 that cycle, next state IDLE, rr_ptr advanced.
6. Assert nRST low during GRANT with out_busy=1.
   -> out_ren and out_wen are 0 asynchronously, req_busy is all ones, rr_ptr=0.
7. Build with GENERIC_BUS_ARB_FIXED_PRIO_EN, requestors 0 and 1 requesting continuously.
   -> Requestor 0 is granted every arbitration.
